pin_sender: RTL and testbench
=============================

PIN_SENDER -- requirements
Module: pin_sender

Interface
REQ-001 Parameter GAP, default 0, idle cycles inserted between consecutive PIN bytes (0..255).
REQ-002 Parameter TIMEOUT, default 2, cycles after the last byte in which unlocked is sampled (1..255).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin an attempt; accepted only when busy=0.
REQ-006 code  input  32  PIN candidate, sampled on accepted start.
REQ-007 sweep  input  1  brute-force enable, sampled on accepted start.
REQ-008 unlocked  input  1  lock status from the safe.
REQ-009 dout  output  8  PIN byte to the safe.
REQ-010 dout_valid  output  1  dout qualifier; high exactly one cycle per byte.
REQ-011 safe_reset  output  1  one-cycle pulse returning the safe to its first-PIN state between sweep attempts.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 success  output  1  result of the last run; held until the next accepted start.
REQ-015 found_code  output  32  last candidate tried; held until the next accepted start.

Function
REQ-016 States SHALL be IDLE, SEND, GAP, WAIT, RESET_SAFE and DONE.
REQ-017 Accepted start in cycle N SHALL latch code and sweep, and SHALL present the first byte with dout_valid=1 in cycle N+1.
REQ-018 Byte order SHALL be code[31:24], [23:16], [15:8], [7:0]; dout SHALL be 0 whenever dout_valid=0.
REQ-019 Between bytes, GAP SHALL spend exactly GAP cycles with dout_valid=0; GAP=0 yields four consecutive valid cycles.
REQ-020 After the fourth byte in cycle M, WAIT SHALL sample unlocked in cycles M+1..M+TIMEOUT; the first high sample SHALL go to DONE with success=1.
REQ-021 If WAIT expires with sweep=0, the block SHALL go to DONE with success=0.
REQ-022 If WAIT expires with sweep=1, RESET_SAFE SHALL pulse safe_reset for one cycle, increment the candidate modulo 2^32, and send the next attempt's first byte in the following cycle.
REQ-023 A failed candidate of 0xFFFFFFFF under sweep SHALL end in DONE with success=0 and no wrap retry.
REQ-024 DONE SHALL last one cycle, pulse done, set found_code to the current candidate, then return to IDLE.
REQ-025 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-026 unlocked high outside WAIT SHALL be ignored.

Reset
REQ-027 reset SHALL force IDLE and set dout, dout_valid, safe_reset, busy, done, success and found_code to 0 on the next edge, including mid-attempt.
REQ-028 Reset SHALL override a coincident start.

Configuration
REQ-029 With PIN_SENDER_SWEEP_EN defined, sweep SHALL behave per REQ-022/REQ-023.
REQ-030 Without PIN_SENDER_SWEEP_EN, sweep SHALL be ignored, every run SHALL be a single attempt, and safe_reset SHALL be constant 0.

Structure
REQ-031 Package safe_pkg SHALL hold the sender state enum, PIN_BYTES=4, BYTE_W=8 and the reference PIN constant 32'hBAADC0DE for benches.
REQ-032 A single sub-module, pin_serializer (byte index plus gap counter, emitting dout/dout_valid and a last-byte flag), is natural; everything else sits in pin_sender.

Verification
REQ-033 GAP=0, code=0xBAADC0DE, start at cycle 0 -> valid bytes BA,AD,C0,DE in cycles 1-4; safe unlocks; done=1, success=1, found_code=0xBAADC0DE.
REQ-034 sweep=0, code=0x00000000, TIMEOUT=2 -> safe locks out; done in cycle 7, success=0, safe_reset never asserted.
REQ-035 sweep=1, code=0xBAADC0DC -> two safe_reset pulses; third attempt succeeds; found_code=0xBAADC0DE.
REQ-036 GAP=2, correct code -> dout_valid in cycles 1, 4, 7 and 10 only.
REQ-037 reset asserted in the cycle after the second byte -> all outputs 0 next cycle; a new start resends from byte 0.
REQ-038 sweep=1, code=0xFFFFFFFF, wrong PIN -> one attempt, then done=1, success=0, found_code=0xFFFFFFFF; start pulses while busy produce no effect.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared sender state encoding, PIN geometry and the reference PIN used by benches.
package safe_pkg;

    localparam int          PIN_BYTES = 4;
    localparam int          BYTE_W    = 8;
    localparam logic [31:0] REF_PIN   = 32'hBAADC0DE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT,
        S_RESET_SAFE,
        S_DONE
    } sender_state_e;

    // Most significant byte goes out first.
    function automatic logic [BYTE_W-1:0] pin_byte(input logic [31:0] code, input logic [1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = code[31:24];
            2'd1:    b = code[23:16];
            2'd2:    b = code[15:8];
            default: b = code[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pin_serializer.sv
// Emits the four PIN bytes of a candidate with GAP idle cycles between them.
// load presents byte 0 on the next cycle; last marks the fourth byte.
module pin_serializer
    import safe_pkg::*;
#(
    parameter int GAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [31:0]       code,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    output logic              last,
    output logic              valid_next
);

    localparam logic [7:0] GAP_CYC = 8'(GAP);

    logic [1:0]        idx_q, idx_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              active_q, active_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              last_q, last_d;

    always_comb begin
        idx_d        = idx_q;
        gap_cnt_d    = gap_cnt_q;
        active_d     = active_q;
        dout_d       = '0;
        dout_valid_d = 1'b0;
        last_d       = 1'b0;
        if (load) begin
            active_d     = 1'b1;
            idx_d        = 2'd1;
            gap_cnt_d    = GAP_CYC;
            dout_d       = pin_byte(code, 2'd0);
            dout_valid_d = 1'b1;
        end else if (active_q) begin
            if (last_q) begin
                active_d = 1'b0;
            end else if (gap_cnt_q != 8'd0) begin
                gap_cnt_d = gap_cnt_q - 8'd1;
            end else begin
                dout_d       = pin_byte(code, idx_q);
                dout_valid_d = 1'b1;
                last_d       = (idx_q == 2'd3);
                idx_d        = idx_q + 2'd1;
                gap_cnt_d    = GAP_CYC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            active_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            gap_cnt_q    <= gap_cnt_d;
            active_q     <= active_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            last_q       <= last_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign last       = last_q;
    assign valid_next = dout_valid_d;

endmodule

// File: rtl/pin_sender.sv
// Sends a 32-bit PIN bytewise to a safe and waits for it to unlock.
// Define PIN_SENDER_SWEEP_EN to enable brute-force sweeping of successive candidates.
module pin_sender
    import safe_pkg::*;
#(
    parameter int GAP     = 0,
    parameter int TIMEOUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       code,
    input  logic              sweep,
    input  logic              unlocked,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    output logic              safe_reset,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [31:0]       found_code
);

`ifdef PIN_SENDER_SWEEP_EN
    localparam logic SWEEP_EN = 1'b1;
`else
    localparam logic SWEEP_EN = 1'b0;
`endif
    localparam logic [7:0] TMO_CYC = 8'(TIMEOUT);

    sender_state_e state_q, state_d;
    logic [31:0]   cand_q, cand_d;
    logic [31:0]   found_code_q, found_code_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          sweep_q, sweep_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          success_q, success_d;
    logic          safe_reset_q, safe_reset_d;
    logic          ser_load, ser_last, ser_valid, ser_valid_next, ser_last_flag;

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        found_code_d = found_code_q;
        wait_cnt_d   = wait_cnt_q;
        sweep_d      = sweep_q;
        busy_d       = busy_q;
        success_d    = success_q;
        done_d       = 1'b0;
        safe_reset_d = 1'b0;
        ser_load     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                cand_d       = code;
                sweep_d      = sweep & SWEEP_EN;
                busy_d       = 1'b1;
                success_d    = 1'b0;
                found_code_d = '0;
                ser_load     = 1'b1;
                state_d      = S_SEND;
            end
            S_SEND, S_GAP: begin
                if (ser_last) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = TMO_CYC;
                end else begin
                    state_d = ser_valid_next ? S_SEND : S_GAP;
                end
            end
            S_WAIT: begin
                if (unlocked) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    success_d    = 1'b1;
                    found_code_d = cand_q;
                end else if (wait_cnt_q == 8'd1) begin
                    // All-ones is the last candidate: never wrap back to zero.
                    if (sweep_q && cand_q != '1) begin
                        state_d      = S_RESET_SAFE;
                        safe_reset_d = 1'b1;
                    end else begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        found_code_d = cand_q;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            S_RESET_SAFE: begin
                cand_d   = cand_q + 32'd1;
                ser_load = 1'b1;
                state_d  = S_SEND;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cand_q       <= '0;
            found_code_q <= '0;
            wait_cnt_q   <= '0;
            sweep_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            success_q    <= 1'b0;
            safe_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            found_code_q <= found_code_d;
            wait_cnt_q   <= wait_cnt_d;
            sweep_q      <= sweep_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            success_q    <= success_d;
            safe_reset_q <= safe_reset_d;
        end
    end

    pin_serializer #(.GAP(GAP)) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load       (ser_load),
        .code       (cand_d),
        .dout       (dout),
        .dout_valid (ser_valid),
        .last       (ser_last_flag),
        .valid_next (ser_valid_next)
    );

    assign ser_last   = ser_valid & ser_last_flag;
    assign dout_valid = ser_valid;
    assign safe_reset = safe_reset_q & SWEEP_EN;
    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign found_code = found_code_q;

endmodule

// File: tb/tb_pin_sender.sv
// Randomised bench for pin_sender: two instances (GAP=0/TIMEOUT=2, GAP=2/TIMEOUT=3)
// against a per-run expected trace derived from the byte/timeout arithmetic.
module tb_pin_sender;
    import safe_pkg::*;

`ifdef PIN_SENDER_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif
    localparam int MAXC = 256;
    localparam int GAPS [2] = '{0, 2};
    localparam int TMOS [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i [2];
    logic [31:0] code_i;
    logic        sweep_i;
    logic        glitch;
    logic        unlocked_i [2];
    logic [7:0]  dout_o [2];
    logic        dv_o [2], sr_o [2], busy_o [2], done_o [2], succ_o [2];
    logic [31:0] found_o [2];

    logic [31:0] safe_sh [2];
    int          safe_cnt [2];
    logic        safe_open [2];

    bit          exp_v [2][MAXC];
    logic [7:0]  exp_dout [2][MAXC];
    bit          exp_sr [2][MAXC];
    int          exp_done [2];
    bit          exp_succ [2];
    logic [31:0] exp_found [2];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pin_sender #(.GAP(0), .TIMEOUT(2)) dut0 (
        .clk(clk), .reset(reset), .start(start_i[0]), .code(code_i), .sweep(sweep_i),
        .unlocked(unlocked_i[0]), .dout(dout_o[0]), .dout_valid(dv_o[0]), .safe_reset(sr_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .success(succ_o[0]), .found_code(found_o[0]));

    pin_sender #(.GAP(2), .TIMEOUT(3)) dut1 (
        .clk(clk), .reset(reset), .start(start_i[1]), .code(code_i), .sweep(sweep_i),
        .unlocked(unlocked_i[1]), .dout(dout_o[1]), .dout_valid(dv_o[1]), .safe_reset(sr_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .success(succ_o[1]), .found_code(found_o[1]));

    // Safe: opens after four consecutive bytes equal to REF_PIN; a fifth byte starts a new entry.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || sr_o[i]) begin
                safe_cnt[i]  <= 0;
                safe_open[i] <= 1'b0;
                safe_sh[i]   <= '0;
            end else if (dv_o[i]) begin
                if (safe_cnt[i] == 4) begin
                    safe_sh[i]   <= {24'd0, dout_o[i]};
                    safe_cnt[i]  <= 1;
                    safe_open[i] <= 1'b0;
                end else begin
                    safe_sh[i]  <= {safe_sh[i][23:0], dout_o[i]};
                    safe_cnt[i] <= safe_cnt[i] + 1;
                    if (safe_cnt[i] == 3 && {safe_sh[i][23:0], dout_o[i]} == REF_PIN)
                        safe_open[i] <= 1'b1;
                end
            end
        end
    end

    assign unlocked_i[0] = safe_open[0] | glitch;
    assign unlocked_i[1] = safe_open[1] | glitch;

    task automatic chk(input string tag, input int i, input int cy, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d cyc%0d: got %0h want %0h", tag, i, cy, obs, exp);
    endtask

    // Expected trace of one run whose start is in cycle 0.
    task automatic build_exp(input int i, input logic [31:0] c0, input bit sw);
        int t, m, gap, tmo;
        logic [31:0] cand;
        bit fin;
        gap = GAPS[i];
        tmo = TMOS[i];
        for (int k = 0; k < MAXC; k++) begin
            exp_v[i][k] = 1'b0; exp_dout[i][k] = '0; exp_sr[i][k] = 1'b0;
        end
        t = 1; cand = c0; fin = 1'b0;
        exp_done[i] = MAXC - 2; exp_succ[i] = 1'b0;
        for (int a = 0; a < 8 && !fin; a++) begin
            for (int b = 0; b < 4; b++) begin
                exp_v[i][t + b*(gap+1)]    = 1'b1;
                exp_dout[i][t + b*(gap+1)] = 8'(cand >> (8*(3-b)));
            end
            m = t + 3*(gap+1);
            if (cand == REF_PIN) begin
                exp_done[i] = m + 2; exp_succ[i] = 1'b1; fin = 1'b1;
            end else if (SWEEP && sw && cand != 32'hFFFF_FFFF) begin
                exp_sr[i][m + tmo + 1] = 1'b1;
                t = m + tmo + 2;
                cand = cand + 32'd1;
            end else begin
                exp_done[i] = m + tmo + 1; exp_succ[i] = 1'b0; fin = 1'b1;
            end
        end
        exp_found[i] = cand;
    endtask

    task automatic check_cycle(input int i, input int cy);
        chk("dout_valid", i, cy, 32'(dv_o[i]), 32'(exp_v[i][cy]));
        chk("dout", i, cy, 32'(dout_o[i]), 32'(exp_dout[i][cy]));
        chk("safe_reset", i, cy, 32'(sr_o[i]), 32'(exp_sr[i][cy]));
        chk("done", i, cy, 32'(done_o[i]), 32'(cy == exp_done[i]));
        chk("busy", i, cy, 32'(busy_o[i]), 32'(cy >= 1 && cy <= exp_done[i]));
        if (cy >= exp_done[i]) begin
            chk("success", i, cy, 32'(succ_o[i]), 32'(exp_succ[i]));
            chk("found_code", i, cy, found_o[i], exp_found[i]);
        end
    endtask

    task automatic chk_zero(input string tag, input int cy);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_dv"}, i, cy, 32'(dv_o[i]), 32'd0);
            chk({tag, "_dout"}, i, cy, 32'(dout_o[i]), 32'd0);
            chk({tag, "_sr"}, i, cy, 32'(sr_o[i]), 32'd0);
            chk({tag, "_busy"}, i, cy, 32'(busy_o[i]), 32'd0);
            chk({tag, "_done"}, i, cy, 32'(done_o[i]), 32'd0);
            chk({tag, "_succ"}, i, cy, 32'(succ_o[i]), 32'd0);
            chk({tag, "_found"}, i, cy, found_o[i], 32'd0);
        end
    endtask

    // One run: start in cycle 0, optional unlocked glitch in cycle 0, optional ignored start pulses.
    task automatic do_run(input logic [31:0] c, input bit sw, input bit glitch_en, input bit extra);
        int last;
        build_exp(0, c, sw);
        build_exp(1, c, sw);
        last = (exp_done[0] > exp_done[1]) ? exp_done[0] : exp_done[1];
        for (int cy = 0; cy <= last + 1; cy++) begin
            @(negedge clk);
            code_i  = (cy == 0) ? c  : $urandom;
            sweep_i = (cy == 0) ? sw : 1'($urandom_range(0, 1));
            glitch  = glitch_en && (cy == 0);
            for (int i = 0; i < 2; i++)
                start_i[i] = (cy == 0) || (extra && cy <= exp_done[i] && $urandom_range(0, 2) == 0);
            for (int i = 0; i < 2; i++)
                check_cycle(i, cy);
        end
        start_i[0] = 1'b0; start_i[1] = 1'b0;
    endtask

    initial begin
        logic [31:0] c;
        bit sw;
        reset = 1'b1; start_i[0] = 1'b0; start_i[1] = 1'b0;
        code_i = '0; sweep_i = 1'b0; glitch = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset", 0);
        reset = 1'b0;

        do_run(REF_PIN, 1'b0, 1'b1, 1'b0);
        do_run(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        do_run(REF_PIN - 32'd2, 1'b1, 1'b0, 1'b1);
        do_run(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);

        // Abort mid-attempt, then hold start high under reset.
        build_exp(0, REF_PIN, 1'b0);
        build_exp(1, REF_PIN, 1'b0);
        for (int cy = 0; cy <= 3; cy++) begin
            @(negedge clk);
            code_i = REF_PIN; sweep_i = 1'b0;
            start_i[0] = (cy == 0); start_i[1] = (cy == 0);
            reset = (cy == 3);
            for (int i = 0; i < 2; i++) check_cycle(i, cy);
        end
        @(negedge clk);
        start_i[0] = 1'b1; start_i[1] = 1'b1;
        chk_zero("midreset", 4);
        @(negedge clk);
        reset = 1'b0; start_i[0] = 1'b0; start_i[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_vs_start_busy", i, 5, 32'(busy_o[i]), 32'd0);
            chk("rst_vs_start_dv", i, 5, 32'(dv_o[i]), 32'd0);
        end
        do_run(REF_PIN, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            sw = 1'($urandom_range(0, 1));
            if (sw) c = ($urandom_range(0, 3) != 0) ? REF_PIN - 32'($urandom_range(0, 3)) : 32'hFFFF_FFFF;
            else    c = ($urandom_range(0, 1) != 0) ? REF_PIN : $urandom;
            do_run(c, sw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
